// File: rtl/flopoco_stream_adapter.sv
// flopoco_stream_adapter: valid/ready stream wrapper around a stall-free, fixed-latency FloPoCo core.
// Optional sticky inf/NaN result flag is built when FLOPOCO_EXC_FLAG_EN is defined.
module flopoco_stream_adapter #(
  parameter int WE         = 8,
  parameter int WF         = 23,
  parameter int LAT        = 7,
  parameter int FIFO_DEPTH = 16,
  localparam int DW        = WE + WF + 3,
  localparam int IW        = $clog2(LAT + 1) + 1,
  localparam int OW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ivalid,
  output logic          iready,
  input  logic [DW-1:0] ix,
  input  logic [DW-1:0] iy,
  output logic          ovalid,
  input  logic          oready,
  output logic [DW-1:0] odata,
  output logic [DW-1:0] core_x,
  output logic [DW-1:0] core_y,
  input  logic [DW-1:0] core_r,
  output logic [IW-1:0] inflight,
  output logic [OW-1:0] occupancy,
  output logic          exc_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [LAT-1:0] vld_sr_q, vld_sr_d;
  logic [OW-1:0]  credits_q, credits_d;
  logic [OW-1:0]  occ_q, occ_d;
  logic [IW-1:0]  inflight_q, inflight_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]  mem_q [FIFO_DEPTH];
  logic [DW-1:0]  mem_d [FIFO_DEPTH];
  logic           accept, push, pop;

  always_comb begin
    iready    = (credits_q != '0);
    accept    = ivalid & iready;
    ovalid    = (occ_q != '0);
    pop       = ovalid & oready;
    push      = vld_sr_q[LAT-1];
    core_x    = accept ? ix : '0;
    core_y    = accept ? iy : '0;
    odata     = ovalid ? mem_q[rd_ptr_q] : '0;
    inflight  = inflight_q;
    occupancy = occ_q;
  end

  // A credit is a FIFO slot reserved at admission, so a result can always be pushed.
  always_comb begin
    vld_sr_d   = (vld_sr_q << 1) | LAT'(accept);
    credits_d  = credits_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;

    case ({accept, pop})
      2'b10:   credits_d = credits_q - OW'(1);
      2'b01:   credits_d = credits_q + OW'(1);
      default: credits_d = credits_q;
    endcase

    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    case ({accept, push})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = core_r;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_q   <= '0;
      credits_q  <= OW'(FIFO_DEPTH);
      occ_q      <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      vld_sr_q   <= vld_sr_d;
      credits_q  <= credits_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: odata is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef FLOPOCO_EXC_FLAG_EN
  logic exc_flag_q, exc_flag_d;

  always_comb begin
    exc_flag_d = exc_flag_q | (push & core_r[DW-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_flag_q <= 1'b0;
    end else begin
      exc_flag_q <= exc_flag_d;
    end
  end

  assign exc_flag = exc_flag_q;
`else
  assign exc_flag = 1'b0;
`endif

endmodule
